// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared widths and window bit indexing for the Harris corner pipeline
package harris_pkg;

  localparam int PIX_W    = 8;
  localparam int GRAD_W   = 9;
  localparam int SUM_W    = 21;
  localparam int RESP_W   = 44;
  localparam int K_SHIFT  = 4;
  localparam int LATENCY  = 7;

  localparam int WIN_N    = 6;
  localparam int WIN_BITS = WIN_N * WIN_N * PIX_W;
  localparam int TAPS     = 16;
  localparam int COORD_W  = 9;

  // LSB of pixel w[p][q] inside the flattened window; must match the window controller
  function automatic int unsigned win_bit_idx(input int unsigned p, input int unsigned q);
    return (p * WIN_N + q) * PIX_W;
  endfunction

endpackage

// File: rtl/harris_response_if.sv
// rtl/harris_response_if.sv - window-in / corner-response-out bus of the Harris stage
interface harris_response_if;
  import harris_pkg::*;

  logic [WIN_BITS-1:0]      window_flat;
  logic                     window_valid;
  logic                     out_valid;
  logic signed [RESP_W-1:0] response;
  logic                     corner;
  logic [COORD_W-1:0]       win_col;
  logic [COORD_W-1:0]       win_row;

  modport master (
    output window_flat, window_valid,
    input  out_valid, response, corner, win_col, win_row
  );

  modport slave (
    input  window_flat, window_valid,
    output out_valid, response, corner, win_col, win_row
  );

endinterface

// File: rtl/harris_sum16.sv
// rtl/harris_sum16.sv - two-stage registered 16-input signed adder tree (groups of four, then final)
module harris_sum16
  import harris_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = SUM_W
) (
  input  logic                    clk,
  input  logic signed [IN_W-1:0]  in_i [TAPS],
  output logic signed [OUT_W-1:0] sum_o
);

  localparam int PART_W = IN_W + 2;

  logic signed [PART_W-1:0] part_q [4];

  always_ff @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      part_q[g] <= PART_W'(in_i[4*g])   + PART_W'(in_i[4*g+1]) +
                   PART_W'(in_i[4*g+2]) + PART_W'(in_i[4*g+3]);
    end
    sum_o <= OUT_W'(part_q[0]) + OUT_W'(part_q[1]) +
             OUT_W'(part_q[2]) + OUT_W'(part_q[3]);
  end

endmodule

// File: rtl/harris_response.sv
// rtl/harris_response.sv - 7-stage Harris corner response: gradients, tensor sums, R = det - trace^2/16, threshold
module harris_response
  import harris_pkg::*;
#(
  parameter int                 IMG_W  = 480,
  parameter int                 IMG_H  = 320,
  parameter logic signed [63:0] THRESH = 64'sd1000000000
) (
  input logic              clk,
  input logic              reset,
  harris_response_if.slave bus
);

  localparam int PROD_W = 2 * GRAD_W;
  localparam int DET_W  = 42;

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [COORD_W-1:0] col_cnt_q, col_cnt_d;
  logic [COORD_W-1:0] row_cnt_q, row_cnt_d;
  logic [COORD_W-1:0] col_pipe_q [LATENCY-1];
  logic [COORD_W-1:0] row_pipe_q [LATENCY-1];

  logic signed [GRAD_W-1:0] ix_d [TAPS];
  logic signed [GRAD_W-1:0] iy_d [TAPS];
  logic signed [GRAD_W-1:0] ix_q [TAPS];
  logic signed [GRAD_W-1:0] iy_q [TAPS];

  logic signed [PROD_W-1:0] pxx_d [TAPS];
  logic signed [PROD_W-1:0] pyy_d [TAPS];
  logic signed [PROD_W-1:0] pxy_d [TAPS];
  logic [15:0]              ixx_q [TAPS];
  logic [15:0]              iyy_q [TAPS];
  logic signed [16:0]       ixy_q [TAPS];

  logic signed [16:0] sxx_in [TAPS];
  logic signed [16:0] syy_in [TAPS];
  logic signed [16:0] sxy_in [TAPS];
  logic signed [SUM_W-1:0] sxx, syy, sxy;

  logic signed [DET_W-1:0]  sxx_syy_q, sxy2_q;
  logic signed [SUM_W:0]    trace;
  logic signed [RESP_W-1:0] tr2_q;
  logic signed [RESP_W-1:0] r_q;

  logic signed [RESP_W-1:0] response_q;
  logic                     corner_q;
  logic [COORD_W-1:0]       win_col_q, win_row_q;

  // The four window corners feed neither gradient
  logic unused_corner_pix;
  assign unused_corner_pix = ^{bus.window_flat[win_bit_idx(0, 0) +: PIX_W],
                               bus.window_flat[win_bit_idx(0, 5) +: PIX_W],
                               bus.window_flat[win_bit_idx(5, 0) +: PIX_W],
                               bus.window_flat[win_bit_idx(5, 5) +: PIX_W]};

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (bus.window_valid) begin
      if (col_cnt_q == COORD_W'(IMG_W - 1)) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == COORD_W'(IMG_H - 6)) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  assign valid_d = {valid_q[LATENCY-2:0], bus.window_valid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Coordinates ride alongside the data, one slot per stage S1..S6
  always_ff @(posedge clk) begin
    col_pipe_q[0] <= col_cnt_q;
    row_pipe_q[0] <= row_cnt_q;
    for (int k = 1; k < LATENCY - 1; k++) begin
      col_pipe_q[k] <= col_pipe_q[k-1];
      row_pipe_q[k] <= row_pipe_q[k-1];
    end
  end

  always_comb begin
    for (int r = 1; r <= 4; r++) begin
      for (int c = 1; c <= 4; c++) begin
        ix_d[(r-1)*4 + (c-1)] =
          $signed({1'b0, bus.window_flat[win_bit_idx(r, c + 1) +: PIX_W]}) -
          $signed({1'b0, bus.window_flat[win_bit_idx(r, c - 1) +: PIX_W]});
        iy_d[(r-1)*4 + (c-1)] =
          $signed({1'b0, bus.window_flat[win_bit_idx(r + 1, c) +: PIX_W]}) -
          $signed({1'b0, bus.window_flat[win_bit_idx(r - 1, c) +: PIX_W]});
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      pxx_d[i]  = PROD_W'(ix_q[i]) * PROD_W'(ix_q[i]);
      pyy_d[i]  = PROD_W'(iy_q[i]) * PROD_W'(iy_q[i]);
      pxy_d[i]  = PROD_W'(ix_q[i]) * PROD_W'(iy_q[i]);
      sxx_in[i] = $signed({1'b0, ixx_q[i]});
      syy_in[i] = $signed({1'b0, iyy_q[i]});
      sxy_in[i] = ixy_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TAPS; i++) begin
      ix_q[i]  <= ix_d[i];
      iy_q[i]  <= iy_d[i];
      ixx_q[i] <= pxx_d[i][15:0];
      iyy_q[i] <= pyy_d[i][15:0];
      ixy_q[i] <= pxy_d[i][16:0];
    end
  end

  harris_sum16 #(.IN_W(17), .OUT_W(SUM_W)) u_sum_xx (.clk(clk), .in_i(sxx_in), .sum_o(sxx));
  harris_sum16 #(.IN_W(17), .OUT_W(SUM_W)) u_sum_yy (.clk(clk), .in_i(syy_in), .sum_o(syy));
  harris_sum16 #(.IN_W(17), .OUT_W(SUM_W)) u_sum_xy (.clk(clk), .in_i(sxy_in), .sum_o(sxy));

  assign trace = (SUM_W+1)'(sxx) + (SUM_W+1)'(syy);

  // Signed throughout: Sxx/Syy are never negative, so the products stay exact
  always_ff @(posedge clk) begin
    sxx_syy_q <= DET_W'(sxx) * DET_W'(syy);
    sxy2_q    <= DET_W'(sxy) * DET_W'(sxy);
    tr2_q     <= RESP_W'(trace) * RESP_W'(trace);
    r_q       <= RESP_W'(sxx_syy_q) - RESP_W'(sxy2_q) - (tr2_q >>> K_SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      response_q <= '0;
      corner_q   <= 1'b0;
      win_col_q  <= '0;
      win_row_q  <= '0;
    end else if (valid_q[LATENCY-2]) begin
      response_q <= r_q;
      corner_q   <= (64'(r_q) > THRESH);
      win_col_q  <= col_pipe_q[LATENCY-2];
      win_row_q  <= row_pipe_q[LATENCY-2];
    end
  end

  assign bus.out_valid = valid_q[LATENCY-1];
  assign bus.response  = response_q;
  assign bus.corner    = corner_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_row   = win_row_q;

endmodule

// File: doc/harris_response.md
# harris_response

Pipelined Harris corner-response stage directly downstream of the line-buffer/window controller. Every cycle it accepts one 6×6 pixel window, with no backpressure. For each window it computes central-difference gradients over the inner 4×4, builds the summed structure tensor, evaluates R = det − trace²/16, and thresholds R. Results leave with window coordinates and a fixed 7-cycle latency toward non-max suppression and output logic.

## Interface
- IMG_W, 480: pixels per image line; also windows per window-row.
- IMG_H, 320: image lines; there are IMG_H−5 window-rows per frame.
- THRESH, 64'sd1000000000: signed threshold; a corner is flagged when R > THRESH.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- window_flat  in  288  window pixel w[p][q] at bits [(p*6+q)*8 +: 8]. p=0 is the oldest line; q=0 is the oldest column. Unsigned 8-bit.
- window_valid  in  1  window_flat is valid this cycle.
- out_valid  out  1  result valid; reset value 0.
- response  out  44  signed R; reset value 0.
- corner  out  1  R > THRESH, qualified by out_valid; reset value 0.
- win_col  out  9  column index of the window's w[0][0], 0..IMG_W−1; reset value 0.
- win_row  out  9  window-row index, 0..IMG_H−6; reset value 0.

## Operation
- Gradients are computed for r,c ∈ 1..4:
  - Ix = w[r][c+1] − w[r][c−1]
  - Iy = w[r+1][c] − w[r−1][c]
  - Both are signed 9-bit, range ±255.
- Products:
  - Ixx = Ix², unsigned 16-bit.
  - Iyy = Iy², unsigned 16-bit.
  - Ixy = Ix·Iy, signed 17-bit.
- Sums over the 16 positions:
  - Sxx and Syy are unsigned 20-bit, max 1,040,400.
  - Sxy is signed 21-bit.
- det = Sxx·Syy − Sxy², signed 42-bit.
- trace = Sxx + Syy, unsigned 21-bit.
- R = det − (trace² >>> 4), signed 44-bit. There is no overflow or saturation at any stage; widths are exact for the worst case.
- corner = (R > THRESH), using a signed compare sign-extended to 64 bits.
- Coordinate counters advance on each accepted window (window_valid=1):
  - col_cnt increments; at IMG_W−1 it wraps to 0 and row_cnt increments.
  - row_cnt wraps to 0 after IMG_H−6.
  - Coordinates are captured at acceptance and carried down the pipe with the data.
- A window_valid gap inserts a bubble and does not disturb in-flight results. Each result keeps its own coordinates and order.
- Reset asserted mid-frame clears every pipeline valid bit, all counters and all outputs asynchronously. No stale result appears after reset releases.

## Timing
- 7-stage pipeline. A window sampled at edge N produces out_valid=1 with its results after edge N+7.
- The stages are:
  - S1 gradients.
  - S2 products.
  - S3 four partial sums of 4 per tensor term.
  - S4 final sums.
  - S5 Sxx·Syy, Sxy², trace².
  - S6 R.
  - S7 compare, registering all outputs.
- Throughput is one window per clock, sustained indefinitely.
- All outputs are registered. When out_valid=0, response, corner and the coordinates hold their last values; consumers must qualify with out_valid.
- The valid shift register is 7 bits and is reset to 0. Data registers need not be reset; only output registers and valid/counters are reset.
- Deassertion of reset must meet recovery timing. The first window is accepted on the first edge after release.

## Structure
- Shared package harris_pkg holds:
  - PIX_W=8, GRAD_W=9, SUM_W=21, RESP_W=44, K_SHIFT=4, LATENCY=7.
  - The window bit-index function shared with the window controller.
- Sub-module harris_sum16 is a 2-stage registered 16-input signed adder tree (stages S3–S4). It is instantiated three times, for Sxx, Syy and Sxy.

## Test plan
- Flat window, all pixels 100, one valid pulse → exactly 7 cycles later out_valid=1 for one cycle, response=0, corner=0, win_col=0, win_row=0.
- Vertical edge, w=0 for q≤2 and 200 for q≥3 → Sxx=320000, Syy=Sxy=0, response=−6,400,000,000, corner=0.
- Corner, w=200 where p≥3 and q≥3 else 0 → Sxx=Syy=160000, Sxy=40000, response=17,600,000,000, corner=1.
- Continuous stream of IMG_W·(IMG_H−5)+1 windows → coordinates step 0..479 per row, the row increments on wrap, the last window of the frame reports (479, 314), and the next reports (0, 0). Exactly one result per input, with no gaps.
- Gapped valid, a 1-on/2-off pattern with distinct windows → outputs in order, each exactly 7 cycles after its input, out_valid following the same pattern.
- Reset low for one cycle while 4 results are in flight → all outputs 0 immediately; no out_valid after release until 7 cycles after a new window; counters restart at (0, 0).
